// File: rtl/autocorr_lag_bank_if.sv
// Bundles the autocorrelation engine's control, sample-memory and result signals.
// The engine connects through the slave modport; its controller connects through the master modport.
interface autocorr_lag_bank_if #(
  parameter int DATA_W   = 12,
  parameter int ADDR_W   = 11,
  parameter int NUM_LAGS = 5,
  parameter int LAG_W    = 8,
  parameter int ACC_W    = 36
);
  localparam int IDX_W = (NUM_LAGS > 1) ? $clog2(NUM_LAGS) : 1;

  logic                      start;
  logic [NUM_LAGS*LAG_W-1:0] lag_table;
  logic [ACC_W-1:0]          min_score;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_data;
  logic                      busy;
  logic                      done;
  logic [IDX_W-1:0]          best_idx;
  logic [ACC_W-1:0]          best_score;
  logic                      pitch_valid;
  logic [IDX_W-1:0]          rd_idx;
  logic [ACC_W-1:0]          rd_score;

  modport master (
    output start, lag_table, min_score, mem_data, rd_idx,
    input  mem_addr, busy, done, best_idx, best_score, pitch_valid, rd_score
  );

  modport slave (
    input  start, lag_table, min_score, mem_data, rd_idx,
    output mem_addr, busy, done, best_idx, best_score, pitch_valid, rd_score
  );
endinterface

// File: rtl/autocorr_lag_bank.sv
// Autocorrelation pitch engine: R(k) = sum x[n]*x[n+lag_k] over a fixed window for each
// programmable lag, read from a 1-cycle synchronous sample memory, plus argmax selection.
module autocorr_lag_bank #(
  parameter int DATA_W   = 12,
  parameter int ADDR_W   = 11,
  parameter int WIN_LEN  = 1861,
  parameter int NUM_LAGS = 5,
  parameter int LAG_W    = 8,
  parameter int ACC_W    = 36
) (
  input logic               clk,
  input logic               rst_n,
  autocorr_lag_bank_if.slave bus
);
  localparam int IDX_W = (NUM_LAGS > 1) ? $clog2(NUM_LAGS) : 1;
  localparam int N_W   = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int S_W   = DATA_W + 1;
  localparam int P_W   = 2 * S_W;
  localparam logic [S_W-1:0] MID = S_W'(1) << (DATA_W - 1);

  typedef enum logic [2:0] {IDLE, PHASE_A, PHASE_B, DRAIN, UPDATE} state_t;

  state_t                   state;
  logic [N_W-1:0]           n;
  logic [IDX_W-1:0]         k;
  logic signed [ACC_W-1:0]  acc;
  logic signed [S_W-1:0]    s_a;
  logic [LAG_W-1:0]         lag_q [NUM_LAGS];
  logic signed [ACC_W-1:0]  min_q;
  logic signed [ACC_W-1:0]  score [NUM_LAGS];
  logic signed [ACC_W-1:0]  best_score;
  logic [IDX_W-1:0]         best_idx;
  logic                     busy;
  logic                     done;
  logic                     pitch_valid;

  // Current read data in bipolar form; in PHASE_A/DRAIN it is the partner sample x[n+lag].
  logic signed [S_W-1:0]    s_in;
  logic signed [P_W-1:0]    prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic                     take_new;
  logic signed [ACC_W-1:0]  next_best;

  assign s_in      = $signed({1'b0, bus.mem_data} - MID);
  assign prod      = P_W'(s_a) * P_W'(s_in);
  assign prod_ext  = {{(ACC_W-P_W){prod[P_W-1]}}, prod};
  assign acc_sum   = acc + prod_ext;
  assign take_new  = (k == '0) || (acc > best_score);
  assign next_best = take_new ? acc : best_score;

  assign bus.mem_addr    = (state == PHASE_B) ? ADDR_W'(n) + ADDR_W'(lag_q[k]) : ADDR_W'(n);
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.best_idx    = best_idx;
  assign bus.best_score  = best_score;
  assign bus.pitch_valid = pitch_valid;
  assign bus.rd_score    = (32'(bus.rd_idx) < 32'(NUM_LAGS)) ? score[bus.rd_idx] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      n           <= '0;
      k           <= '0;
      acc         <= '0;
      s_a         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      best_score  <= '0;
      best_idx    <= '0;
      pitch_valid <= 1'b0;
      for (int i = 0; i < NUM_LAGS; i++) score[i] <= '0;
    end else if (bus.start) begin
      // A start always wins, so a running computation is dropped without a done pulse.
      for (int i = 0; i < NUM_LAGS; i++) lag_q[i] <= bus.lag_table[i*LAG_W +: LAG_W];
      min_q       <= $signed(bus.min_score);
      state       <= PHASE_A;
      n           <= '0;
      k           <= '0;
      acc         <= '0;
      busy        <= 1'b1;
      done        <= 1'b0;
      best_score  <= '0;
      best_idx    <= '0;
      pitch_valid <= 1'b0;
      for (int i = 0; i < NUM_LAGS; i++) score[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        PHASE_A: begin
          if (n != '0) acc <= acc_sum;
          state <= PHASE_B;
        end
        PHASE_B: begin
          s_a <= s_in;
          if (n == N_W'(WIN_LEN - 1)) begin
            state <= DRAIN;
          end else begin
            n     <= n + N_W'(1);
            state <= PHASE_A;
          end
        end
        DRAIN: begin
          acc   <= acc_sum;
          state <= UPDATE;
        end
        UPDATE: begin
          score[k]   <= acc;
          best_score <= next_best;
          if (take_new) best_idx <= k;
          acc <= '0;
          n   <= '0;
          if (k == IDX_W'(NUM_LAGS - 1)) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b1;
            pitch_valid <= (next_best > min_q);
          end else begin
            k     <= k + IDX_W'(1);
            state <= PHASE_A;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_autocorr_lag_bank.sv
// Bench for autocorr_lag_bank: a timeline/arithmetic model checked every cycle,
// plus directed runs with hand-computed scores, latencies and addresses.
module tb_autocorr_lag_bank;
  localparam int DATA_W   = 12;
  localparam int ADDR_W   = 6;
  localparam int WIN_LEN  = 40;
  localparam int NUM_LAGS = 3;
  localparam int LAG_W    = 8;
  localparam int ACC_W    = 36;
  localparam int IDX_W    = 2;
  localparam int PER      = 2 * WIN_LEN + 2;
  localparam int TOTAL    = NUM_LAGS * PER;
  localparam int MEM_SIZE = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  autocorr_lag_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_LAGS(NUM_LAGS),
                         .LAG_W(LAG_W), .ACC_W(ACC_W)) bus ();

  autocorr_lag_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WIN_LEN(WIN_LEN),
                      .NUM_LAGS(NUM_LAGS), .LAG_W(LAG_W), .ACC_W(ACC_W))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  logic [DATA_W-1:0] mem [MEM_SIZE];

  always @(posedge clk) bus.mem_data <= mem[bus.mem_addr];

  task automatic check_output(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint wrap_acc(input longint v);
    longint r;
    r = v & ((longint'(1) << ACC_W) - 1);
    if (r >= (longint'(1) << (ACC_W - 1))) r = r - (longint'(1) << ACC_W);
    return r;
  endfunction

  function automatic longint compute_score(input int lag);
    longint sum = 0;
    for (int i = 0; i < WIN_LEN; i++)
      sum += longint'(int'(mem[i]) - 2048) * longint'(int'(mem[(i + lag) % MEM_SIZE]) - 2048);
    return wrap_acc(sum);
  endfunction

  // Model: mode 0 = before first reset, 1 = cleared, 2 = run started m_cyc cycles ago.
  int     m_mode = 0;
  int     m_cyc = 0;
  int     m_lag [NUM_LAGS];
  longint m_min;
  longint m_score [NUM_LAGS];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 1;
    end else if (bus.start === 1'b1) begin
      m_mode = 2;
      m_cyc  = 1;
      m_min  = wrap_acc(longint'(bus.min_score));
      for (int i = 0; i < NUM_LAGS; i++) begin
        m_lag[i]   = int'(bus.lag_table[i*LAG_W +: LAG_W]);
        m_score[i] = compute_score(m_lag[i]);
      end
    end else if (m_mode == 2) begin
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    int     fin;
    int     o;
    int     ei;
    int     ri;
    longint eb;
    longint er;
    longint ea;
    if (m_mode == 1) begin
      check_output("busy_clr", longint'(bus.busy), 0);
      check_output("done_clr", longint'(bus.done), 0);
      check_output("best_idx_clr", longint'(bus.best_idx), 0);
      check_output("best_score_clr", longint'(bus.best_score), 0);
      check_output("pitch_clr", longint'(bus.pitch_valid), 0);
      check_output("rd_score_clr", longint'(bus.rd_score), 0);
      check_output("mem_addr_clr", longint'(bus.mem_addr), 0);
    end else if (m_mode == 2) begin
      fin = (m_cyc - 1) / PER;
      if (fin > NUM_LAGS) fin = NUM_LAGS;
      eb = 0;
      ei = 0;
      for (int j = 0; j < fin; j++)
        if (j == 0 || m_score[j] > eb) begin
          eb = m_score[j];
          ei = j;
        end
      ri = int'(bus.rd_idx);
      er = (ri < fin) ? m_score[ri] : 0;
      check_output("busy", longint'(bus.busy), longint'(m_cyc <= TOTAL));
      check_output("done", longint'(bus.done), longint'(m_cyc == TOTAL + 1));
      check_output("best_idx", longint'(bus.best_idx), longint'(ei));
      check_output("best_score", wrap_acc(longint'(bus.best_score)), eb);
      check_output("pitch_valid", longint'(bus.pitch_valid), longint'(m_cyc > TOTAL && eb > m_min));
      check_output("rd_score", wrap_acc(longint'(bus.rd_score)), er);
      if (m_cyc <= TOTAL) begin
        o = (m_cyc - 1) % PER;
        if (o < 2 * WIN_LEN) begin
          ea = (o % 2 == 0) ? longint'(o / 2)
                            : longint'((o / 2 + m_lag[(m_cyc - 1) / PER]) % MEM_SIZE);
          check_output("mem_addr", longint'(bus.mem_addr), ea);
        end
      end
    end
  end

  longint addr_log [256];

  task automatic apply_stimulus(input int l0, input int l1, input int l2, input longint min_s);
    @(posedge clk); #1;
    bus.lag_table = {LAG_W'(l2), LAG_W'(l1), LAG_W'(l0)};
    bus.min_score = ACC_W'(min_s);
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
  endtask

  // Returns the cycle (counting the one after the start edge as 1) in which done is seen.
  task automatic wait_done(input int limit, output int cnt);
    cnt = 0;
    forever begin
      @(negedge clk);
      cnt++;
      if (cnt < 256) addr_log[cnt] = longint'(bus.mem_addr);
      if (bus.done === 1'b1) return;
      if (cnt >= limit) begin
        check_output("done_timeout", 0, 1);
        return;
      end
      @(posedge clk); #1;
      bus.rd_idx = IDX_W'(cnt % 4);
    end
  endtask

  task automatic read_score(input int idx, output longint val);
    @(posedge clk); #1;
    bus.rd_idx = IDX_W'(idx);
    @(negedge clk);
    val = wrap_acc(longint'(bus.rd_score));
  endtask

  initial begin
    int     cnt;
    longint s0, s1, s2, s3;
    bus.start     = 1'b0;
    bus.lag_table = '0;
    bus.min_score = '0;
    bus.rd_idx    = '0;
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = 12'd2048;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_output("reset_busy", longint'(bus.busy), 0);
    check_output("reset_addr", longint'(bus.mem_addr), 0);

    $display("[TB] run 1: flat midscale memory");
    apply_stimulus(5, 10, 3, 0);
    wait_done(1000, cnt);
    check_output("t1_latency", cnt, 247);
    check_output("t1_best_score", wrap_acc(longint'(bus.best_score)), 0);
    check_output("t1_pitch", longint'(bus.pitch_valid), 0);
    read_score(1, s1);
    check_output("t1_score1", s1, 0);

    $display("[TB] run 2: square wave period 10");
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = (i % 10 < 5) ? 12'd3048 : 12'd1048;
    apply_stimulus(5, 10, 3, 0);
    wait_done(1000, cnt);
    check_output("t2_latency", cnt, 247);
    check_output("t2_best_idx", longint'(bus.best_idx), 1);
    check_output("t2_pitch", longint'(bus.pitch_valid), 1);
    check_output("t2_addr_c1", addr_log[1], 0);
    check_output("t2_addr_c2", addr_log[2], 5);
    check_output("t2_addr_c3", addr_log[3], 1);
    check_output("t2_addr_c4", addr_log[4], 6);
    check_output("t2_addr_c79", addr_log[79], 39);
    check_output("t2_addr_c80", addr_log[80], 44);
    check_output("t2_addr_c83", addr_log[83], 0);
    check_output("t2_addr_c84", addr_log[84], 10);
    read_score(0, s0);
    read_score(1, s1);
    read_score(2, s2);
    read_score(3, s3);
    check_output("t2_score0", s0, -40000000);
    check_output("t2_score1", s1, 40000000);
    check_output("t2_score2", s2, -8000000);
    check_output("t2_rd_idx3", s3, 0);

    $display("[TB] run 3: tied lags");
    apply_stimulus(10, 10, 5, 0);
    wait_done(1000, cnt);
    check_output("t3_best_idx", longint'(bus.best_idx), 0);
    read_score(0, s0);
    read_score(1, s1);
    check_output("t3_score0", s0, 40000000);
    check_output("t3_score1", s1, 40000000);

    $display("[TB] run 4: restart while busy");
    apply_stimulus(5, 10, 3, 0);
    repeat (98) @(posedge clk);
    apply_stimulus(3, 5, 10, 0);
    wait_done(1000, cnt);
    check_output("t4_latency", cnt, 247);
    check_output("t4_best_idx", longint'(bus.best_idx), 2);

    $display("[TB] run 5: reset mid-run");
    apply_stimulus(5, 10, 3, 100);
    repeat (50) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_output("t5_busy", longint'(bus.busy), 0);
    check_output("t5_addr", longint'(bus.mem_addr), 0);
    repeat (300) @(posedge clk);
    check_output("t5_no_done", longint'(bus.busy), 0);

    $display("[TB] run 6: address wrap with lag 30");
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = DATA_W'((i * 37 + 100) % 4096);
    apply_stimulus(30, 1, 2, -5);
    wait_done(1000, cnt);
    check_output("t6_latency", cnt, 247);
    check_output("t6_addr_c80", addr_log[80], 5);
    check_output("t6_addr_c2", addr_log[2], 30);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
